load_store_unit: RTL

//  Initiator side of the data-memory interface. Takes one CPU load/store request
//  (LB/LBU/LH/LHU/LW/SB/SH/SW) and sequences word-addressed accesses to data_memory:
//  - Memory has a combinational read and a write-enabled clocked write.
//  - Sub-word stores become read-modify-write.

---
 rtl/load_store_unit_pkg.sv | 35 +++
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit_lane_align.sv | 37 +++
 rtl/load_store_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcode and FSM state encodings
// plus small opcode classification helpers.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic is_store(lsu_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_half(lsu_op_e op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic is_word(lsu_op_e op);
        return op inside {OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request / response and data-memory signals of the load/store unit.
// master = core + memory side, slave = the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte/half lane handling: load extract with sign/zero extension, and store merge.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = word[{off, 3'b000} +: 8];
        lane_h    = off[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = word;
        case (op)
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'h0, lane_b};
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'h0, lane_h};
            OP_SB:   merged[{off, 3'b000} +: 8] = wdata[7:0];
            OP_SH: begin
                if (off[1]) merged[31:16] = wdata;
                else        merged[15:0]  = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer towards a word-addressed data memory; MISALIGN_TRAP_EN traps misaligned half/word.
// Latency accept->resp: loads 2, SW 2, SB/SH 3 (read-modify-write), errors 1.
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 100
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     req_op, op_q;
    logic [1:0]  req_off, off_q;
    logic [31:0] addr_q, wd_q, rdata_q;
    logic        err_q;
    logic        accept, misalign, out_of_range, req_err;
    logic [31:0] load_data, merged;

    assign req_op       = lsu_op_e'(bus.req_op);
    assign accept       = bus.req_valid && (state_q == ST_IDLE);
    // Index beyond the memory errors out instead of wrapping.
    assign out_of_range = {2'b00, bus.req_addr[31:2]} >= 32'(MEM_DEPTH);
    assign req_err      = out_of_range | misalign;

    always_comb begin
        misalign = 1'b0;
        req_off  = bus.req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
        if (is_half(req_op) && bus.req_addr[0])           misalign = 1'b1;
        if (is_word(req_op) && (bus.req_addr[1:0] != 2'b00)) misalign = 1'b1;
`else
        if (is_half(req_op)) req_off = {bus.req_addr[1], 1'b0};
        if (is_word(req_op)) req_off = 2'b00;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)              state_d = ST_RESP;
                    else if (req_op == OP_SW) state_d = ST_WRITE;
                    else                      state_d = ST_READ;
                end
            end
            ST_READ:  state_d = is_store(op_q) ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_LB;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            wd_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                off_q   <= req_off;
                addr_q  <= {2'b00, bus.req_addr[31:2]};
                wd_q    <= bus.req_wdata;
                rdata_q <= 32'h0;
                err_q   <= req_err;
            end
            // wd_q holds raw store data until the read phase replaces it with the merged word.
            if (state_q == ST_READ) begin
                if (is_store(op_q)) wd_q    <= merged;
                else                rdata_q <= load_data;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .op        (op_q),
        .off       (off_q),
        .word      (bus.mem_rd),
        .wdata     (wd_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_err   = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = (state_q == ST_WRITE);
    assign bus.mem_wd     = wd_q;

endmodule
